// File: rtl/gol_matrix_scan_if.sv
// rtl/gol_matrix_scan_if.sv - generation input and LED matrix output bundle for gol_matrix_scan
//
// Signals:
//   grid        64  generation to display; row r = grid[8r+7:8r], bit c = column c
//   grid_valid   1  one-cycle strobe qualifying grid
//   row_sel      8  one-hot row enable (inverted in the active-low build)
//   col_data     8  column drive for the selected row (inverted in the active-low build)
//   frame_done   1  one-cycle pulse on the last scan cycle of row 7
//   pending      1  a captured generation waits for the next frame boundary
// Modports: master = generation source / matrix sink, slave = gol_matrix_scan.
interface gol_matrix_scan_if;
    logic [63:0] grid;
    logic        grid_valid;
    logic [7:0]  row_sel;
    logic [7:0]  col_data;
    logic        frame_done;
    logic        pending;

    modport master (
        output grid,
        output grid_valid,
        input  row_sel,
        input  col_data,
        input  frame_done,
        input  pending
    );

    modport slave (
        input  grid,
        input  grid_valid,
        output row_sel,
        output col_data,
        output frame_done,
        output pending
    );
endinterface

// File: rtl/gol_matrix_scan.sv
// rtl/gol_matrix_scan.sv - multiplexed 8x8 LED matrix scanner for the Game-of-Life grid
//
// Scans the displayed generation one row at a time: BLANK all-off cycles, then
// DWELL lit cycles per row. New generations are captured into a pending buffer
// and only swapped into the displayed copy at the row-7 frame boundary.
//
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  asynchronous active-low reset
//   bus    gol_matrix_scan_if.slave (grid, grid_valid in; row_sel, col_data,
//          frame_done, pending out)
// Parameters: DWELL (lit cycles per row, >= 1), BLANK (off cycles before each row).
// Build option: GOL_SCAN_ACTIVE_LOW_EN inverts row_sel/col_data (off = 8'hFF).
module gol_matrix_scan #(
    parameter int DWELL = 1000,
    parameter int BLANK = 2
) (
    input  logic             clk,
    input  logic             reset,
    gol_matrix_scan_if.slave bus
);

    localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);

`ifdef GOL_SCAN_ACTIVE_LOW_EN
    localparam logic [7:0] OFF = 8'hFF;
`else
    localparam logic [7:0] OFF = 8'h00;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_SHOW
    } state_t;

    // Each row begins with blanking unless blanking is configured away.
    localparam state_t ROW_START = (BLANK == 0) ? S_SHOW : S_BLANK;

    state_t          state;
    state_t          nxt_state;
    logic [2:0]      row;
    logic [2:0]      nxt_row;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   nxt_cnt;
    logic [63:0]     shadow;
    logic [63:0]     pend_buf;
    logic            pend_flag;
    logic            boundary;
    logic [7:0]      row_sel_q;
    logic [7:0]      col_data_q;
    logic            frame_done_q;

    assign boundary = (state == S_SHOW) && (row == 3'd7) && (cnt == DWELL_LAST);

    always_comb begin
        nxt_state = state;
        nxt_row   = row;
        nxt_cnt   = cnt;
        unique case (state)
            S_IDLE: begin
                if (bus.grid_valid) begin
                    nxt_state = ROW_START;
                    nxt_row   = 3'd0;
                    nxt_cnt   = '0;
                end
            end
            S_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    nxt_state = S_SHOW;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt = cnt + CW'(1);
                end
            end
            S_SHOW: begin
                if (cnt == DWELL_LAST) begin
                    nxt_state = ROW_START;
                    nxt_row   = row + 3'd1;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt = cnt + CW'(1);
                end
            end
            default: begin
                nxt_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            row          <= 3'd0;
            cnt          <= '0;
            shadow       <= 64'd0;
            pend_buf     <= 64'd0;
            pend_flag    <= 1'b0;
            row_sel_q    <= OFF;
            col_data_q   <= OFF;
            frame_done_q <= 1'b0;
        end else begin
            state <= nxt_state;
            row   <= nxt_row;
            cnt   <= nxt_cnt;

            if (state == S_IDLE) begin
                if (bus.grid_valid) begin
                    shadow <= bus.grid;
                end
            end else if (boundary) begin
                // A strobe coinciding with the boundary beats the older buffered one.
                if (bus.grid_valid) begin
                    shadow <= bus.grid;
                end else if (pend_flag) begin
                    shadow <= pend_buf;
                end
                pend_flag <= 1'b0;
            end else if (bus.grid_valid) begin
                pend_buf  <= bus.grid;
                pend_flag <= 1'b1;
            end

            // Registered from the next-state decode so the pulse lands on the
            // boundary cycle itself, where a coincident strobe goes straight to shadow.
            frame_done_q <= (nxt_state == S_SHOW) && (nxt_row == 3'd7) && (nxt_cnt == DWELL_LAST);

            // Drive registers follow the state one cycle behind.
            if (state == S_SHOW) begin
                row_sel_q  <= (8'd1 << row) ^ OFF;
                col_data_q <= shadow[{row, 3'b000} +: 8] ^ OFF;
            end else begin
                row_sel_q  <= OFF;
                col_data_q <= OFF;
            end
        end
    end

    assign bus.row_sel    = row_sel_q;
    assign bus.col_data   = col_data_q;
    assign bus.frame_done = frame_done_q;
    assign bus.pending    = pend_flag;

endmodule
